fu_status_table: RTL and testbench

Parametrised scalar functional-unit status table (scoreboard) between dispatch and issue. It tracks one row per functional unit (busy, destination, sources, pending producer tags) plus a per-register result-status array. It gates dispatch on structural and WAW hazards, raises per-FU issue readiness when both source operands are available, and clears dependencies on writeback broadcast.

---
 rtl/fu_status_table_pkg.sv | 39 +++
 rtl/fu_status_table_reg_status.sv | 45 ++++
 rtl/fu_status_table.sv | 152 +++++++++++++++
 tb/tb_fu_status_table.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_status_table_pkg.sv
// Shared types for the scalar functional-unit status table.
// Default geometry: three FUs (ALU, LD_ST, BRANCH), 32 architectural registers.
package fu_status_table_pkg;

    localparam int FUST_NUM_FU = 3;
    localparam int FUST_REG_W  = 5;
    localparam int FU_W        = $clog2(FUST_NUM_FU);
    localparam int TAG_W       = $clog2(FUST_NUM_FU + 1);

    // Producer tag: 0 = operand ready, k = result pending from FU k-1
    typedef logic [TAG_W-1:0] tag_t;
    // FU index
    typedef logic [FU_W-1:0]  fu_tag_t;

    typedef enum logic [FU_W-1:0] {
        FU_ALU    = 2'd0,
        FU_LD_ST  = 2'd1,
        FU_BRANCH = 2'd2
    } fu_scalar_e;

    // One status-table row, MSB first: busy, issued, rd, rs1, rs2, t1, t2
    typedef struct packed {
        logic                  busy;
        logic                  issued;
        logic [FUST_REG_W-1:0] rd;
        logic [FUST_REG_W-1:0] rs1;
        logic [FUST_REG_W-1:0] rs2;
        tag_t                  t1;
        tag_t                  t2;
    } fust_row_t;

    localparam int ROW_W = $bits(fust_row_t);

    // Tag that a given FU broadcasts on writeback
    function automatic tag_t fu_to_tag(input fu_tag_t fu);
        return tag_t'(fu) + tag_t'(1);
    endfunction

endpackage

// File: rtl/fu_status_table_reg_status.sv
// Result-status array: one producer tag per architectural register.
// Register 0 is hardwired to tag 0 (never written, always reads 0).
module fust_reg_status #(
    parameter int REG_W = 5,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_all,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic [TAG_W-1:0] clr_tag,
    input  logic [REG_W-1:0] rd_idx,
    input  logic [REG_W-1:0] rs1_idx,
    input  logic [REG_W-1:0] rs2_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [TAG_W-1:0] rs2_tag
);
    import fu_status_table_pkg::*;

    localparam int NREG = 1 << REG_W;

    logic [TAG_W-1:0] stat [NREG];

    // Clear-on-match from writeback, set from dispatch; set wins on the same entry
    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            for (int i = 0; i < NREG; i++) stat[i] <= '0;
        end else begin
            if (clr_en && clr_idx != '0 && stat[clr_idx] == clr_tag)
                stat[clr_idx] <= '0;
            if (set_en && set_idx != '0)
                stat[set_idx] <= set_tag;
        end
    end

    assign rd_tag  = (rd_idx  == '0) ? '0 : stat[rd_idx];
    assign rs1_tag = (rs1_idx == '0) ? '0 : stat[rs1_idx];
    assign rs2_tag = (rs2_idx == '0) ? '0 : stat[rs2_idx];

endmodule

// File: rtl/fu_status_table.sv
// Scalar functional-unit status table (scoreboard) between dispatch and issue.
// Optional feature macro: FUST_FLUSH_EN adds a flush port that wipes all state.
module fu_status_table #(
    parameter int NUM_FU = 3,
    parameter int REG_W  = 5,
    parameter int FU_W   = $clog2(NUM_FU),
    parameter int TAG_W  = $clog2(NUM_FU + 1),
    parameter int ROW_W  = 2 + 3 * REG_W + 2 * TAG_W
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef FUST_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    disp_valid,
    input  logic [FU_W-1:0]         disp_fu,
    input  logic [REG_W-1:0]        disp_rd,
    input  logic [REG_W-1:0]        disp_rs1,
    input  logic [REG_W-1:0]        disp_rs2,
    output logic                    disp_ready,
    output logic [NUM_FU-1:0]       issue_ready,
    input  logic [NUM_FU-1:0]       issue_fire,
    input  logic                    wb_valid,
    input  logic [FU_W-1:0]         wb_fu,
    output logic [NUM_FU-1:0]       busy_o,
    output logic [NUM_FU*ROW_W-1:0] row_o
);
    import fu_status_table_pkg::*;

    typedef struct packed {
        logic             busy;
        logic             issued;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [TAG_W-1:0] t1;
        logic [TAG_W-1:0] t2;
    } row_t;

    row_t [NUM_FU-1:0] rows;
    row_t              new_row;

    logic             flush_req;
    logic             disp_fu_ok, wb_fu_ok;
    logic             disp_busy, wb_busy, wb_issued;
    logic [REG_W-1:0] wb_rd;
    logic             wb_eff, disp_acc;
    logic [TAG_W-1:0] wb_tag, disp_tag;
    logic [TAG_W-1:0] rd_tag, rs1_tag, rs2_tag;

`ifdef FUST_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign disp_fu_ok = {1'b0, disp_fu} < (FU_W+1)'(NUM_FU);
    assign wb_fu_ok   = {1'b0, wb_fu}   < (FU_W+1)'(NUM_FU);
    assign wb_tag     = TAG_W'(wb_fu)   + TAG_W'(1);
    assign disp_tag   = TAG_W'(disp_fu) + TAG_W'(1);

    // Select the rows addressed by dispatch and writeback without out-of-range indexing
    always_comb begin
        disp_busy = 1'b0;
        wb_busy   = 1'b0;
        wb_issued = 1'b0;
        wb_rd     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (FU_W'(k) == disp_fu) disp_busy = rows[k].busy;
            if (FU_W'(k) == wb_fu) begin
                wb_busy   = rows[k].busy;
                wb_issued = rows[k].issued;
                wb_rd     = rows[k].rd;
            end
        end
    end

    // A writeback only counts for a row that has actually been issued
    assign wb_eff = wb_valid && wb_fu_ok && wb_busy && wb_issued && !flush_req;

    // Structural (FU busy) and WAW (rd still pending) hazards block dispatch
    assign disp_ready = !flush_req && disp_fu_ok && !disp_busy &&
                        (disp_rd == '0 || rd_tag == '0);
    assign disp_acc   = disp_valid && disp_ready;

    // New row; sources produced by this cycle's writeback are bypassed to ready
    always_comb begin
        new_row        = '0;
        new_row.busy   = 1'b1;
        new_row.issued = 1'b0;
        new_row.rd     = disp_rd;
        new_row.rs1    = disp_rs1;
        new_row.rs2    = disp_rs2;
        new_row.t1     = (wb_eff && rs1_tag == wb_tag) ? '0 : rs1_tag;
        new_row.t2     = (wb_eff && rs2_tag == wb_tag) ? '0 : rs2_tag;
    end

    // Row readiness and busy flags
    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            issue_ready[k] = rows[k].busy && !rows[k].issued &&
                             rows[k].t1 == '0 && rows[k].t2 == '0;
            busy_o[k]      = rows[k].busy;
        end
    end

    assign row_o = rows;

    // Row state: writeback retires, dispatch fills, issue marks, broadcast wakes up
    always_ff @(posedge clk) begin
        if (rst || flush_req) begin
            rows <= '0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (wb_eff && FU_W'(k) == wb_fu) begin
                    rows[k] <= '0;
                end else if (disp_acc && FU_W'(k) == disp_fu) begin
                    rows[k] <= new_row;
                end else begin
                    if (issue_fire[k] && issue_ready[k])
                        rows[k].issued <= 1'b1;
                    if (wb_eff && rows[k].t1 == wb_tag)
                        rows[k].t1 <= '0;
                    if (wb_eff && rows[k].t2 == wb_tag)
                        rows[k].t2 <= '0;
                end
            end
        end
    end

    fust_reg_status #(
        .REG_W (REG_W),
        .TAG_W (TAG_W)
    ) u_reg_status (
        .clk     (clk),
        .rst     (rst),
        .clr_all (flush_req),
        .set_en  (disp_acc),
        .set_idx (disp_rd),
        .set_tag (disp_tag),
        .clr_en  (wb_eff),
        .clr_idx (wb_rd),
        .clr_tag (wb_tag),
        .rd_idx  (disp_rd),
        .rs1_idx (disp_rs1),
        .rs2_idx (disp_rs2),
        .rd_tag  (rd_tag),
        .rs1_tag (rs1_tag),
        .rs2_tag (rs2_tag)
    );

endmodule

// File: tb/tb_fu_status_table.sv
// Self-checking bench for fu_status_table: directed scenarios plus random
// traffic compared against a behavioural scoreboard model.
module tb_fu_status_table;
    import fu_status_table_pkg::*;

    localparam int N  = FUST_NUM_FU;
    localparam int RW = FUST_REG_W;
    localparam int FW = FU_W;
    localparam int RN = 1 << RW;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_tb;
    logic              disp_valid;
    logic [FW-1:0]     disp_fu;
    logic [RW-1:0]     disp_rd, disp_rs1, disp_rs2;
    logic              disp_ready;
    logic [N-1:0]      issue_ready, issue_fire, busy_o;
    logic              wb_valid;
    logic [FW-1:0]     wb_fu;
    logic [N*ROW_W-1:0] row_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit m_busy [N];
    bit m_iss  [N];
    int m_rd [N], m_rs1 [N], m_rs2 [N], m_t1 [N], m_t2 [N];
    int m_rstat [RN];

    always #5 clk = ~clk;

    fu_status_table dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FUST_FLUSH_EN
        .flush       (flush_tb),
`endif
        .disp_valid  (disp_valid),
        .disp_fu     (disp_fu),
        .disp_rd     (disp_rd),
        .disp_rs1    (disp_rs1),
        .disp_rs2    (disp_rs2),
        .disp_ready  (disp_ready),
        .issue_ready (issue_ready),
        .issue_fire  (issue_fire),
        .wb_valid    (wb_valid),
        .wb_fu       (wb_fu),
        .busy_o      (busy_o),
        .row_o       (row_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit flush_on();
`ifdef FUST_FLUSH_EN
        return flush_tb;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_disp_ready();
        if (flush_on()) return 0;
        if (int'(disp_fu) >= N) return 0;
        if (m_busy[disp_fu]) return 0;
        if (disp_rd != 0 && m_rstat[disp_rd] != 0) return 0;
        return 1;
    endfunction

    function automatic bit m_ready(input int k);
        return m_busy[k] && !m_iss[k] && m_t1[k] == 0 && m_t2[k] == 0;
    endfunction

    function automatic logic [N-1:0] m_ready_vec();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_ready(k);
        return v;
    endfunction

    function automatic logic [N-1:0] m_busy_vec();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_busy[k];
        return v;
    endfunction

    function automatic logic [N*ROW_W-1:0] m_row_vec();
        logic [N*ROW_W-1:0] v;
        fust_row_t r;
        for (int k = 0; k < N; k++) begin
            r.busy   = m_busy[k];
            r.issued = m_iss[k];
            r.rd     = RW'(m_rd[k]);
            r.rs1    = RW'(m_rs1[k]);
            r.rs2    = RW'(m_rs2[k]);
            r.t1     = tag_t'(m_t1[k]);
            r.t2     = tag_t'(m_t2[k]);
            v[k*ROW_W +: ROW_W] = r;
        end
        return v;
    endfunction

    function automatic fust_row_t dut_row(input int k);
        return fust_row_t'(row_o[k*ROW_W +: ROW_W]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_busy[k] = 0; m_iss[k] = 0;
            m_rd[k] = 0; m_rs1[k] = 0; m_rs2[k] = 0; m_t1[k] = 0; m_t2[k] = 0;
        end
        for (int r = 0; r < RN; r++) m_rstat[r] = 0;
    endtask

    // One clock of scoreboard rules, evaluated on the pre-edge state
    task automatic model_step();
        bit [N-1:0] rdy;
        bit acc, wb_ok;
        int tg, t1n, t2n, wf, df;
        acc   = disp_valid && m_disp_ready();
        df    = int'(disp_fu);
        wf    = int'(wb_fu);
        rdy   = m_ready_vec();
        wb_ok = wb_valid && wf < N && m_busy[wf] && m_iss[wf];
        tg    = wf + 1;
        t1n   = (disp_rs1 == 0) ? 0 : m_rstat[disp_rs1];
        t2n   = (disp_rs2 == 0) ? 0 : m_rstat[disp_rs2];
        if (wb_ok && t1n == tg) t1n = 0;
        if (wb_ok && t2n == tg) t2n = 0;
        for (int k = 0; k < N; k++)
            if (issue_fire[k] && rdy[k]) m_iss[k] = 1;
        if (wb_ok) begin
            if (m_rstat[m_rd[wf]] == tg) m_rstat[m_rd[wf]] = 0;
            for (int k = 0; k < N; k++) begin
                if (m_t1[k] == tg) m_t1[k] = 0;
                if (m_t2[k] == tg) m_t2[k] = 0;
            end
            m_busy[wf] = 0; m_iss[wf] = 0;
            m_rd[wf] = 0; m_rs1[wf] = 0; m_rs2[wf] = 0; m_t1[wf] = 0; m_t2[wf] = 0;
        end
        if (acc) begin
            m_busy[df] = 1; m_iss[df] = 0;
            m_rd[df] = int'(disp_rd); m_rs1[df] = int'(disp_rs1); m_rs2[df] = int'(disp_rs2);
            m_t1[df] = t1n; m_t2[df] = t2n;
            if (disp_rd != 0) m_rstat[disp_rd] = df + 1;
        end
    endtask

    task automatic set_in(input bit dv, input int fu, input int rd, input int rs1, input int rs2,
                          input int fire, input bit wv, input int wfu);
        disp_valid = dv;
        disp_fu    = FW'(fu);
        disp_rd    = RW'(rd);
        disp_rs1   = RW'(rs1);
        disp_rs2   = RW'(rs2);
        issue_fire = N'(fire);
        wb_valid   = wv;
        wb_fu      = FW'(wfu);
    endtask

    // Called at a falling edge with inputs applied: compare, clock, advance model
    task automatic step_check();
        #1;
        chk("disp_ready",  64'(disp_ready),  64'(m_disp_ready()));
        chk("issue_ready", 64'(issue_ready), 64'(m_ready_vec()));
        chk("busy_o",      64'(busy_o),      64'(m_busy_vec()));
        chk("row_o",       64'(row_o),       64'(m_row_vec()));
        @(posedge clk);
        if (rst || flush_on()) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    initial begin
        flush_tb = 1'b0;
        rst      = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Reset state and first dispatch
        set_in(1, 0, 3, 1, 2, 0, 0, 0);
        #1;
        chk("rst_busy",        64'(busy_o),      64'h0);
        chk("rst_issue_ready", 64'(issue_ready), 64'h0);
        chk("rst_row",         64'(row_o),       64'h0);
        chk("rst_disp_ready",  64'(disp_ready),  64'h1);
        step_check();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("disp_busy",  64'(busy_o),        64'h1);
        chk("disp_ready0",64'(issue_ready),   64'h1);
        chk("disp_t1",    64'(dut_row(0).t1), 64'h0);
        chk("disp_t2",    64'(dut_row(0).t2), 64'h0);
        step_check();

        // RAW dependency and writeback wake-up
        set_in(0, 0, 0, 0, 0, 3'b001, 0, 0); step_check();
        set_in(1, 1, 4, 3, 0, 0, 0, 0);      step_check();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("raw_t1",     64'(dut_row(1).t1), 64'h1);
        chk("raw_ready1", 64'(issue_ready[1]), 64'h0);
        step_check();
        set_in(0, 0, 0, 0, 0, 0, 1, 0); step_check();
        set_in(1, 0, 3, 0, 0, 0, 0, 0);
        #1;
        chk("wake_t1",     64'(dut_row(1).t1),  64'h0);
        chk("wake_ready1", 64'(issue_ready[1]), 64'h1);
        chk("rstat3_free", 64'(disp_ready),     64'h1);
        step_check();

        // WAW on r3 held by fu0
        set_in(1, 2, 3, 0, 0, 3'b001, 0, 0);
        #1; chk("waw_block", 64'(disp_ready), 64'h0);
        step_check();
        set_in(1, 2, 3, 0, 0, 0, 1, 0);
        #1; chk("waw_same_wb", 64'(disp_ready), 64'h0);
        step_check();
        set_in(1, 2, 3, 0, 0, 0, 0, 0);
        #1; chk("waw_release", 64'(disp_ready), 64'h1);
        step_check();

        // Structural hazard on fu1
        set_in(1, 1, 7, 0, 0, 3'b010, 0, 0);
        #1; chk("struct_block", 64'(disp_ready), 64'h0);
        step_check();
        set_in(1, 1, 7, 0, 0, 0, 1, 1);
        #1; chk("struct_same_wb", 64'(disp_ready), 64'h0);
        step_check();
        set_in(1, 1, 7, 0, 0, 0, 0, 0);
        #1; chk("struct_release", 64'(disp_ready), 64'h1);
        step_check();
        set_in(0, 0, 0, 0, 0, 3'b010, 0, 0); step_check();

        // Bypass: wb fu1 (rd 7) alongside a dispatch reading r7
        set_in(1, 0, 9, 0, 7, 0, 1, 1);
        #1; chk("bypass_acc", 64'(disp_ready), 64'h1);
        step_check();
        set_in(1, 3, 10, 0, 0, 0, 0, 0);
        #1;
        chk("bypass_t2",     64'(dut_row(0).t2),  64'h0);
        chk("bypass_ready0", 64'(issue_ready[0]), 64'h1);
        chk("fu_oob",        64'(disp_ready),     64'h0);
        step_check();

        // Random traffic with a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            int wf;
            wf = int'($urandom_range(0, N - 1));
            set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   m_iss[wf] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0), wf);
            rst = (i == 700);
`ifdef FUST_FLUSH_EN
            flush_tb = ($urandom_range(0, 63) == 0);
`endif
            step_check();
        end
        rst      = 1'b0;
        flush_tb = 1'b0;

`ifdef FUST_FLUSH_EN
        // Flush with three busy rows holding pending tags
        rst = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0); step_check(); rst = 1'b0;
        set_in(1, 0, 1, 0, 0, 0, 0, 0); step_check();
        set_in(1, 1, 2, 1, 0, 0, 0, 0); step_check();
        set_in(1, 2, 3, 2, 1, 0, 0, 0); step_check();
        flush_tb = 1'b1;
        set_in(1, 0, 4, 0, 0, 3'b001, 0, 0);
        #1; chk("flush_block", 64'(disp_ready), 64'h0);
        step_check();
        flush_tb = 1'b0;
        set_in(1, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("flush_busy",  64'(busy_o),     64'h0);
        chk("flush_ready", 64'(disp_ready), 64'h1);
        step_check();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
